// File: rtl/adc_rst_pkg.sv
// Shared types and default constants for the ADC reset sequencer.
package adc_rst_pkg;

    typedef enum logic [2:0] {
        ST_ADC_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } rst_seq_state_t;

    localparam int DEF_ADC_RST_CYCLES = 16;
    localparam int DEF_LOCK_FILT      = 8;
    localparam int DEF_LOCK_TIMEOUT   = 1024;
    localparam int DEF_SETTLE_CYCLES  = 64;
    localparam int DEF_MAX_RETRIES    = 3;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_rst_sequencer_lock_debounce.sv
// Consecutive-ones filter on pll_locked. done is asserted combinationally
// on the edge where the run of ones reaches LOCK_FILT, so the parent can
// change state on that same edge.
module lock_debounce #(
    parameter int LOCK_FILT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic lock_in,
    output logic done
);
    localparam int W = $clog2(LOCK_FILT + 1);
    localparam logic [W-1:0] FILT_LAST = W'(LOCK_FILT - 1);
    localparam logic [W-1:0] FILT_MAX  = W'(LOCK_FILT);

    logic [W-1:0] cnt;

    assign done = lock_in && (cnt == FILT_LAST);

    // Count consecutive lock cycles; any drop or clear restarts the run, saturate at LOCK_FILT.
    always_ff @(posedge clk) begin
        if (rst || clr || !lock_in)
            cnt <= '0;
        else if (cnt != FILT_MAX)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/adc_rst_sequencer.sv
// ADC front-end bring-up: pulse the chip reset, wait for a debounced lock
// with timeout and bounded retries, settle, then release the capture path.
module adc_rst_sequencer
    import adc_rst_pkg::*;
#(
    parameter int ADC_RST_CYCLES = DEF_ADC_RST_CYCLES,
    parameter int LOCK_FILT      = DEF_LOCK_FILT,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             soft_rst,
    input  logic                             pll_locked,
    output logic                             adc_rst,
    output logic                             dp_rst,
    output logic                             ready,
    output logic                             fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [2:0]                       state_o
);
    // One counter serves ADC_RST, WAIT_LOCK (timeout) and SETTLE since only
    // one phase is active at a time and it is cleared on every state entry.
    localparam int CNT_W = $clog2(max3(ADC_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(ADC_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    rst_seq_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             restart;
    logic             lock_done;
    logic             attempt_fail;

    assign restart = rst || soft_rst;

    lock_debounce #(.LOCK_FILT(LOCK_FILT)) u_lock_debounce (
        .clk     (clk),
        .rst     (restart),
        .clr     (state_q != ST_WAIT_LOCK),
        .lock_in (pll_locked),
        .done    (lock_done)
    );

    // State, counter and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= ST_ADC_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            adc_rst <= 1'b1;
            dp_rst  <= 1'b1;
            ready   <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            adc_rst <= (state_d == ST_ADC_RST);
            dp_rst  <= (state_d != ST_RUN);
            ready   <= (state_d == ST_RUN);
            fail    <= (state_d == ST_FAIL);
        end
    end

    // Next-state, phase counter and retry bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        retry_d      = retry_q;
        attempt_fail = 1'b0;
        case (state_q)
            ST_ADC_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same edge.
                if (lock_done) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!pll_locked) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == SET_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!pll_locked)
                    state_d = ST_ADC_RST;
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_ADC_RST;
                cnt_d   = '0;
            end
        endcase
        if (attempt_fail) begin
            retry_d = retry_q + 1'b1;
            cnt_d   = '0;
            state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_ADC_RST;
        end
    end

    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_adc_rst_sequencer.sv
// Directed bench for adc_rst_sequencer with a phase/elapsed-time model and
// literal checkpoints at the hand-computed edges.
module tb_adc_rst_sequencer;
    localparam int P_ARC = 4;
    localparam int P_LF  = 2;
    localparam int P_LT  = 16;
    localparam int P_SC  = 3;
    localparam int P_MR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_rst = 1'b0;
    logic       pll_locked = 1'b1;
    logic       adc_rst, dp_rst, ready, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    adc_rst_sequencer #(
        .ADC_RST_CYCLES(P_ARC), .LOCK_FILT(P_LF), .LOCK_TIMEOUT(P_LT),
        .SETTLE_CYCLES(P_SC), .MAX_RETRIES(P_MR)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .pll_locked(pll_locked),
        .adc_rst(adc_rst), .dp_rst(dp_rst), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase (spec state code), edges spent in the phase, trailing run of lock=1
    int m_phase = 0, m_elapsed = 0, m_ones = 0, m_retry = 0;
    bit m_valid = 1'b0;

    task automatic enter(input int ph);
        m_phase = ph; m_elapsed = 0; m_ones = 0;
    endtask

    task automatic lose_attempt();
        m_retry = m_retry + 1;
        enter((m_retry == P_MR) ? 4 : 0);
    endtask

    always @(posedge clk) begin
        if (rst || soft_rst) begin
            enter(0); m_retry = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                0: begin
                    m_elapsed++;
                    if (m_elapsed == P_ARC) enter(1);
                end
                1: begin
                    m_elapsed++;
                    m_ones = pll_locked ? m_ones + 1 : 0;
                    if (m_ones >= P_LF) enter(2);
                    else if (m_elapsed >= P_LT) lose_attempt();
                end
                2: begin
                    if (!pll_locked) lose_attempt();
                    else begin
                        m_elapsed++;
                        if (m_elapsed == P_SC) begin enter(3); m_retry = 0; end
                    end
                end
                3: if (!pll_locked) enter(0);
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("m_state",   int'(state_o),   m_phase);
            cmp("m_adc_rst", int'(adc_rst),   int'(m_phase == 0));
            cmp("m_dp_rst",  int'(dp_rst),    int'(m_phase != 3));
            cmp("m_ready",   int'(ready),     int'(m_phase == 3));
            cmp("m_fail",    int'(fail),      int'(m_phase == 4));
            cmp("m_retry",   int'(retry_cnt), m_retry);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held for three edges
        tick(3);
        cmp("rst_state", int'(state_o), 0);
        cmp("rst_adc", int'(adc_rst), 1);
        cmp("rst_dp", int'(dp_rst), 1);
        cmp("rst_ready", int'(ready), 0);
        cmp("rst_fail", int'(fail), 0);
        cmp("rst_retry", int'(retry_cnt), 0);
        rst = 1'b0;

        // Nominal bring-up
        tick(3); cmp("nom_adc_e3", int'(adc_rst), 1);
        tick(1); cmp("nom_adc_e4", int'(adc_rst), 0);
        tick(4); cmp("nom_ready_e8", int'(ready), 0);
        cmp("nom_dp_e8", int'(dp_rst), 1);
        tick(1); cmp("nom_ready_e9", int'(ready), 1);
        cmp("nom_dp_e9", int'(dp_rst), 0);
        cmp("nom_state_e9", int'(state_o), 3);

        // Lock loss in RUN
        tick(2);
        pll_locked = 1'b0;
        tick(1);
        cmp("loss_ready", int'(ready), 0);
        cmp("loss_dp", int'(dp_rst), 1);
        cmp("loss_adc", int'(adc_rst), 1);
        cmp("loss_retry", int'(retry_cnt), 0);
        pll_locked = 1'b1;
        tick(8); cmp("relock_e8", int'(ready), 0);
        tick(1); cmp("relock_e9", int'(ready), 1);

        // Lock bounce 1,0,1,1 (soft_rst out of RUN; pll toggles in ADC_RST ignored)
        soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
        cmp("soft_run_state", int'(state_o), 0);
        pll_locked = 1'b0; tick(1); pll_locked = 1'b1; tick(1);
        pll_locked = 1'b0; tick(2);
        pll_locked = 1'b1; tick(1);
        pll_locked = 1'b0; tick(1);
        pll_locked = 1'b1; tick(1);
        cmp("bounce_wait", int'(state_o), 1);
        tick(1);
        cmp("bounce_settle", int'(state_o), 2);
        cmp("bounce_retry", int'(retry_cnt), 0);

        // soft_rst mid-SETTLE
        tick(1);
        soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
        cmp("soft_settle_state", int'(state_o), 0);
        cmp("soft_settle_adc", int'(adc_rst), 1);
        cmp("soft_settle_fail", int'(fail), 0);
        cmp("soft_settle_retry", int'(retry_cnt), 0);

        // Retry then FAIL with no lock at all
        pll_locked = 1'b0;
        tick(19); cmp("to_e19_retry", int'(retry_cnt), 0);
        cmp("to_e19_state", int'(state_o), 1);
        tick(1); cmp("to_e20_retry", int'(retry_cnt), 1);
        cmp("to_e20_state", int'(state_o), 0);
        tick(19); cmp("to_e39_fail", int'(fail), 0);
        tick(1); cmp("to_e40_fail", int'(fail), 1);
        cmp("to_e40_state", int'(state_o), 4);
        cmp("to_e40_adc", int'(adc_rst), 0);
        cmp("to_e40_dp", int'(dp_rst), 1);
        tick(10); cmp("fail_sticky", int'(fail), 1);
        pll_locked = 1'b1; tick(5); cmp("fail_sticky_lock", int'(fail), 1);

        // soft_rst out of FAIL
        soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
        cmp("soft_fail_state", int'(state_o), 0);
        cmp("soft_fail_fail", int'(fail), 0);
        cmp("soft_fail_retry", int'(retry_cnt), 0);
        cmp("soft_fail_adc", int'(adc_rst), 1);

        // Back to FAIL, then rst+soft_rst together
        pll_locked = 1'b0; tick(40);
        cmp("fail2", int'(fail), 1);
        rst = 1'b1; soft_rst = 1'b1; tick(1); rst = 1'b0; soft_rst = 1'b0;
        cmp("both_state", int'(state_o), 0);
        cmp("both_fail", int'(fail), 0);
        cmp("both_retry", int'(retry_cnt), 0);
        cmp("both_adc", int'(adc_rst), 1);

        // Lock completes on the timeout edge: lock wins
        tick(18); pll_locked = 1'b1;
        tick(1); cmp("simul_e19", int'(state_o), 1);
        tick(1); cmp("simul_e20", int'(state_o), 2);
        cmp("simul_retry", int'(retry_cnt), 0);
        tick(3); cmp("simul_ready", int'(ready), 1);

        // Lock lost during SETTLE counts as a failed attempt
        soft_rst = 1'b1; tick(1); soft_rst = 1'b0;
        tick(7);
        cmp("sdrop_in_settle", int'(state_o), 2);
        pll_locked = 1'b0; tick(1);
        cmp("sdrop_state", int'(state_o), 0);
        cmp("sdrop_retry", int'(retry_cnt), 1);
        pll_locked = 1'b1; tick(8);
        cmp("sdrop_retry_held", int'(retry_cnt), 1);
        tick(1);
        cmp("sdrop_ready", int'(ready), 1);
        cmp("sdrop_retry_clr", int'(retry_cnt), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
